// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-lane width and the alignment rule.
package lsu_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } lsu_state_e;

  // An access is rejected for an illegal size or a natural-alignment violation.
  function automatic logic access_error(lsu_size_e sz, logic [1:0] off);
    logic err;
    case (sz)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = off[0];
      SIZE_WORD: err = (off != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: merges store data into a word and extracts/extends
// load data from a word, little-endian lane order.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] word_i,
  input  lsu_size_e    size_i,
  input  logic [1:0]   offset_i,
  input  logic         unsigned_i,
  input  logic [n-1:0] store_data_i,
  output logic [n-1:0] merged_o,
  output logic [n-1:0] load_o
);

  logic [LANE_W-1:0]   byte_v;
  logic [2*LANE_W-1:0] half_v;
  logic                byte_sx;
  logic                half_sx;

  assign byte_v  = word_i[{offset_i, 3'b000} +: LANE_W];
  assign half_v  = word_i[{offset_i[1], 4'b0000} +: 2*LANE_W];
  assign byte_sx = ~unsigned_i & byte_v[LANE_W-1];
  assign half_sx = ~unsigned_i & half_v[2*LANE_W-1];

  always_comb begin
    merged_o = word_i;
    load_o   = word_i;
    case (size_i)
      SIZE_BYTE: begin
        merged_o[{offset_i, 3'b000} +: LANE_W] = store_data_i[LANE_W-1:0];
        load_o = {{(n-LANE_W){byte_sx}}, byte_v};
      end
      SIZE_HALF: begin
        merged_o[{offset_i[1], 4'b0000} +: 2*LANE_W] = store_data_i[2*LANE_W-1:0];
        load_o = {{(n-2*LANE_W){half_sx}}, half_v};
      end
      default: begin
        merged_o = store_data_i;
        load_o   = word_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/halfword/word accesses to a word-wide dmem,
// using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         req,
  input  logic         isStore,
  input  logic [1:0]   size,
  input  logic         unsignedLoad,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] storeData,
  output logic         busy,
  output logic         done,
  output logic         misaligned,
  output logic [n-1:0] loadData,
  output logic [n-1:0] memAddr,
  output logic         memWriteEnable,
  output logic [n-1:0] memWriteData,
  input  logic [n-1:0] memReadData
);

  if (n < 32 || r < 1 || r + 2 > n) begin : g_param_check
    $error("load_store_unit: unsupported parameters n=%0d r=%0d", n, r);
  end

  lsu_state_e  state_q;
  logic [n-1:0] addr_q;
  lsu_size_e    size_q;
  logic         store_q;
  logic         uns_q;
  logic [n-1:0] sdata_q;
  logic [n-1:0] buf_q;
  logic [n-1:0] load_q;
  logic         done_q;
  logic         mis_q;

  logic [n-1:0] lane_word;
  logic [n-1:0] merged;
  logic [n-1:0] load_val;
  logic         req_err;

  // In READ the lanes see the word being captured, so the extended load value
  // can be registered on the same edge and is valid in the done cycle.
  assign lane_word = (state_q == READ) ? memReadData : buf_q;
  assign req_err   = access_error(lsu_size_e'(size), addr[1:0]);

  lsu_lane #(.n(n)) u_lane (
    .word_i       (lane_word),
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .unsigned_i   (uns_q),
    .store_data_i (sdata_q),
    .merged_o     (merged),
    .load_o       (load_val)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      sdata_q <= '0;
      buf_q   <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            size_q  <= lsu_size_e'(size);
            store_q <= isStore;
            uns_q   <= unsignedLoad;
            sdata_q <= storeData;
            if (req_err) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else if (isStore && lsu_size_e'(size) == SIZE_WORD) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          buf_q <= memReadData;
          if (store_q) begin
            state_q <= WRITE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            load_q  <= load_val;
          end
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    memAddr = '0;
    if (state_q == READ || state_q == WRITE) begin
      memAddr = {addr_q[n-1:2], 2'b00};
    end
  end

  assign memWriteEnable = (state_q == WRITE) && rstN;
  assign memWriteData   = merged;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign misaligned     = mis_q;
  assign loadData       = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed dmem and a
// scoreboard of expected completions.
module tb_load_store_unit;

  localparam int N = 32;
  localparam int R = 6;

  logic         clk = 1'b0;
  logic         rstN;
  logic         req;
  logic         isStore;
  logic [1:0]   size;
  logic         unsignedLoad;
  logic [N-1:0] addr;
  logic [N-1:0] storeData;
  logic         busy;
  logic         done;
  logic         misaligned;
  logic [N-1:0] loadData;
  logic [N-1:0] memAddr;
  logic         memWriteEnable;
  logic [N-1:0] memWriteData;
  logic [N-1:0] memReadData;

  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  int          wr_cnt = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lat;
    logic        mis;
    logic [31:0] data;
    int          writes;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.n(N), .r(R)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .req            (req),
    .isStore        (isStore),
    .size           (size),
    .unsignedLoad   (unsignedLoad),
    .addr           (addr),
    .storeData      (storeData),
    .busy           (busy),
    .done           (done),
    .misaligned     (misaligned),
    .loadData       (loadData),
    .memAddr        (memAddr),
    .memWriteEnable (memWriteEnable),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData)
  );

  assign memReadData = mem[memAddr[R+1:2]];

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[memAddr[R+1:2]] <= memWriteData;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_access(input string tag, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d,
                           input int lat, input logic mis, input logic [31:0] data,
                           input int writes);
    exp_t e;
    exp_t got;
    int   l;
    int   w0;
    logic mis_o;
    logic [31:0] ld;
    e.lat = lat; e.mis = mis; e.data = data; e.writes = writes;
    sb_q.push_back(e);
    wait_idle();
    isStore = st; size = sz; unsignedLoad = uns; addr = a; storeData = d;
    req = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    l = 1;
    while (!done && l < 12) begin
      @(posedge clk);
      #1;
      l++;
    end
    mis_o = misaligned;
    ld = loadData;
    got = sb_q.pop_front();
    check({tag, "_latency"}, 32'(l), 32'(got.lat));
    check({tag, "_misaligned"}, {31'd0, mis_o}, {31'd0, got.mis});
    check({tag, "_loadData"}, ld, got.data);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(got.writes));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int dn;
    rstN = 1'b0; req = 1'b0; isStore = 1'b0; size = 2'b00; unsignedLoad = 1'b0;
    addr = '0; storeData = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
    check("reset_loadData", loadData, 32'd0);
    check("reset_memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
    check("reset_memAddr", memAddr, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // word store then word load
    do_access("sw_54", 1'b1, 2'b10, 1'b0, 32'h54, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
    check("sw_54_mem", mem[21], 32'hDEADBEEF);
    do_access("lw_54", 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

    // byte store read-modify-write
    preload(6'd42, 32'h11223344);
    do_access("sb_AA", 1'b1, 2'b00, 1'b0, 32'hAA, 32'h000000AC, 3, 1'b0, 32'hDEADBEEF, 1);
    check("sb_AA_mem", mem[42], 32'h11AC3344);

    // sub-word load extension
    preload(6'd63, 32'h80FF7F01);
    do_access("lb_FE", 1'b0, 2'b00, 1'b0, 32'hFE, 32'h0, 2, 1'b0, 32'hFFFFFFFF, 0);
    do_access("lbu_FE", 1'b0, 2'b00, 1'b1, 32'hFE, 32'h0, 2, 1'b0, 32'h000000FF, 0);
    do_access("lh_FE", 1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 2, 1'b0, 32'hFFFF80FF, 0);
    do_access("lhu_FC", 1'b0, 2'b01, 1'b1, 32'hFC, 32'h0, 2, 1'b0, 32'h00007F01, 0);

    // halfword store into upper lanes
    do_access("sh_56", 1'b1, 2'b01, 1'b0, 32'h56, 32'h1234BEEF, 3, 1'b0, 32'h00007F01, 1);
    check("sh_56_mem", mem[21], 32'hBEEFBEEF);

    // error cases
    do_access("lh_55_err", 1'b0, 2'b01, 1'b0, 32'h55, 32'h0, 1, 1'b1, 32'h00007F01, 0);
    do_access("sw_56_err", 1'b1, 2'b10, 1'b0, 32'h56, 32'h12345678, 1, 1'b1, 32'h00007F01, 0);
    do_access("size11_ld_err", 1'b0, 2'b11, 1'b0, 32'h54, 32'h0, 1, 1'b1, 32'h00007F01, 0);
    do_access("size11_st_err", 1'b1, 2'b11, 1'b0, 32'h54, 32'h99, 1, 1'b1, 32'h00007F01, 0);
    check("err_mem_unchanged", mem[21], 32'hBEEFBEEF);

    // top byte lane, sign-extended
    do_access("lb_57", 1'b0, 2'b00, 1'b0, 32'h57, 32'h0, 2, 1'b0, 32'hFFFFFFBE, 0);

    // requests while busy and in the done cycle are ignored
    preload(6'd16, 32'h0);
    preload(6'd17, 32'h0);
    wait_idle();
    isStore = 1'b1; size = 2'b10; unsignedLoad = 1'b0; addr = 32'h40; storeData = 32'h1;
    req = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    addr = 32'h44; storeData = 32'h99;
    @(posedge clk);
    #1;
    check("busy_ign_done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("busy_ign_idle", {31'd0, busy}, 32'd0);
    check("busy_ign_writes", 32'(wr_cnt - w0), 32'd1);
    check("busy_ign_mem16", mem[16], 32'h1);
    check("busy_ign_mem17", mem[17], 32'h0);

    // req held high: word store accepted every third cycle
    wait_idle();
    isStore = 1'b1; size = 2'b10; addr = 32'h40; storeData = 32'hCAFEF00D;
    req = 1'b1;
    w0 = wr_cnt;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    req = 1'b0;
    check("held_req_dones", 32'(dn), 32'd4);
    check("held_req_writes", 32'(wr_cnt - w0), 32'd4);
    check("held_req_mem16", mem[16], 32'hCAFEF00D);

    // reset during the WRITE cycle of a byte store
    wait_idle();
    isStore = 1'b1; size = 2'b00; unsignedLoad = 1'b0; addr = 32'hA8; storeData = 32'h55;
    req = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_in_write_we", {31'd0, memWriteEnable}, 32'd1);
    rstN = 1'b0;
    #1;
    check("rst_mid_we_gated", {31'd0, memWriteEnable}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_loadData", loadData, 32'd0);
    check("rst_mid_writes", 32'(wr_cnt - w0), 32'd0);
    check("rst_mid_mem", mem[42], 32'h11AC3344);
    @(negedge clk);
    rstN = 1'b1;

    do_access("lw_A8_after_rst", 1'b0, 2'b10, 1'b0, 32'hA8, 32'h0, 2, 1'b0, 32'h11AC3344, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
